// File: rtl/operand_entry.sv
// Keypad front-end: debounces scanner key/pressed, builds two 2-digit BCD operands and the op,
// and strobes each accepted key (plus result_valid on entry to RESULT) to the datapath.
module operand_entry #(
  parameter int STABLE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key,
  input  logic       pressed,
  output logic [3:0] a_ten,
  output logic [3:0] a_one,
  output logic [3:0] b_ten,
  output logic [3:0] b_one,
  output logic       op,
  output logic [1:0] state,
  output logic       key_strobe,
  output logic       result_valid
);

  localparam logic [7:0] LIMIT = 8'(STABLE_CNT);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    RESULT  = 2'd2
  } state_t;

  localparam logic [3:0] K_ADD = 4'd10;
  localparam logic [3:0] K_SUB = 4'd11;
  localparam logic [3:0] K_CLR = 4'd12;
  localparam logic [3:0] K_EQ  = 4'd14;

  state_t     cur, nxt;
  logic       armed;
  logic [7:0] cnt;
  logic [3:0] cand;
  logic       accept;
  logic       is_digit, is_op, is_clr, is_eq;
  logic [3:0] a_ten_n, a_one_n, b_ten_n, b_one_n;
  logic       op_n, rv_n;

  // The final qualifying sample is the one that would bring the count to STABLE_CNT.
  always_comb accept = armed && pressed && (key == cand) && (cnt == LIMIT - 8'd1);

  always_comb begin
    is_digit = (key < 4'd10);
    is_op    = (key == K_ADD) || (key == K_SUB);
    is_clr   = (key == K_CLR);
    is_eq    = (key == K_EQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b1;
      cnt   <= 8'd0;
      cand  <= 4'd0;
    end else if (armed) begin
      if (!pressed) begin
        cnt <= 8'd0;
      end else if (key != cand) begin
        cand <= key;
        cnt  <= 8'd1;
      end else if (accept) begin
        armed <= 1'b0;
        cnt   <= 8'd0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end else begin
      if (pressed) begin
        cnt <= 8'd0;
      end else if (cnt == LIMIT - 8'd1) begin
        armed <= 1'b1;
        cnt   <= 8'd0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= ENTER_A;
    else        cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    if (accept) begin
      if (is_clr) begin
        nxt = ENTER_A;
      end else begin
        case (cur)
          ENTER_A: if (is_op) nxt = ENTER_B;
          ENTER_B: if (is_eq) nxt = RESULT;
          RESULT: begin
            if (is_digit)   nxt = ENTER_A;
            else if (is_op) nxt = ENTER_B;
          end
          default: nxt = ENTER_A;
        endcase
      end
    end
  end

  always_comb begin
    a_ten_n = a_ten;
    a_one_n = a_one;
    b_ten_n = b_ten;
    b_one_n = b_one;
    op_n    = op;
    rv_n    = 1'b0;
    if (accept) begin
      if (is_clr) begin
        a_ten_n = 4'd0; a_one_n = 4'd0;
        b_ten_n = 4'd0; b_one_n = 4'd0;
        op_n    = 1'b0;
      end else begin
        case (cur)
          ENTER_A: begin
            if (is_digit) begin
              a_ten_n = a_one;
              a_one_n = key;
            end else if (is_op) begin
              op_n    = (key == K_SUB);
              b_ten_n = 4'd0; b_one_n = 4'd0;
            end
          end
          ENTER_B: begin
            if (is_digit) begin
              b_ten_n = b_one;
              b_one_n = key;
            end else if (is_op) begin
              op_n = (key == K_SUB);
            end else if (is_eq) begin
              rv_n = 1'b1;
            end
          end
          RESULT: begin
            if (is_digit) begin
              a_ten_n = 4'd0; a_one_n = key;
              b_ten_n = 4'd0; b_one_n = 4'd0;
              op_n    = 1'b0;
            end else if (is_op) begin
              op_n    = (key == K_SUB);
              b_ten_n = 4'd0; b_one_n = 4'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_ten        <= 4'd0;
      a_one        <= 4'd0;
      b_ten        <= 4'd0;
      b_one        <= 4'd0;
      op           <= 1'b0;
      key_strobe   <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      a_ten        <= a_ten_n;
      a_one        <= a_one_n;
      b_ten        <= b_ten_n;
      b_one        <= b_one_n;
      op           <= op_n;
      key_strobe   <= accept;
      result_valid <= rv_n;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with STABLE_CNT=4 and hand-computed expectations.
module tb_operand_entry;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key;
  logic       pressed;
  logic [3:0] a_ten, a_one, b_ten, b_one;
  logic       op;
  logic [1:0] state;
  logic       key_strobe, result_valid;

  int n_cmp = 0;
  int n_err = 0;
  int strobes = 0;
  int rv_cnt = 0;
  int rv_bad = 0;

  operand_entry #(.STABLE_CNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .pressed(pressed),
    .a_ten(a_ten), .a_one(a_one), .b_ten(b_ten), .b_one(b_one),
    .op(op), .state(state), .key_strobe(key_strobe), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock, sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (key_strobe) strobes++;
    if (result_valid) begin
      rv_cnt++;
      if (!key_strobe) rv_bad++;
    end
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int rel, output int lat);
    lat = -1;
    for (int i = 0; i < hold; i++) begin
      key = k;
      pressed = 1'b1;
      tick();
      if (key_strobe && lat < 0) lat = i;
    end
    for (int i = 0; i < rel; i++) begin
      pressed = 1'b0;
      tick();
    end
  endtask

  task automatic tap(input logic [3:0] k);
    int l;
    press(k, 6, 6, l);
  endtask

  task automatic check_all(input string tag, input int at, input int ao, input int bt,
                           input int bo, input int o, input int s);
    check({tag, ".a_ten"}, a_ten, at);
    check({tag, ".a_one"}, a_one, ao);
    check({tag, ".b_ten"}, b_ten, bt);
    check({tag, ".b_one"}, b_one, bo);
    check({tag, ".op"}, op, o);
    check({tag, ".state"}, state, s);
  endtask

  initial begin
    int lat;
    int s0;
    rst_n = 1'b0;
    key = 4'd0;
    pressed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0, 0, 0);
    check("reset.key_strobe", key_strobe, 0);
    check("reset.result_valid", result_valid, 0);
    rst_n = 1'b1;
    tick();

    // 4 then 7, each strobing on the 4th sampled edge (index 3)
    press(4'd4, 6, 6, lat);
    check("lat4", lat, 3);
    press(4'd7, 6, 6, lat);
    check("lat7", lat, 3);
    check("strobes47", strobes, 2);
    check_all("a47", 4, 7, 0, 0, 0, 0);

    // 1,2,3 leaves 23; then SUB 5 EQ
    tap(4'd1); tap(4'd2); tap(4'd3);
    check("a23.ten", a_ten, 2);
    check("a23.one", a_one, 3);
    tap(4'd11); tap(4'd5); tap(4'd14);
    check_all("sub5eq", 2, 3, 0, 5, 1, 2);
    check("rv_count", rv_cnt, 1);
    check("rv_coincident", rv_bad, 0);

    // bounce with ignored code 13: high3 low1 high3 -> nothing
    s0 = strobes;
    press(4'd13, 3, 1, lat);
    press(4'd13, 3, 6, lat);
    check("bounce_none", strobes - s0, 0);
    // held4 low2 high5 -> single event
    s0 = strobes;
    press(4'd13, 4, 2, lat);
    press(4'd13, 5, 6, lat);
    check("bounce_one", strobes - s0, 1);
    check_all("ignored13", 2, 3, 0, 5, 1, 2);

    // key 3 for two samples then 8: count restarts, one event with digit 8 (from RESULT)
    s0 = strobes;
    key = 4'd3; pressed = 1'b1;
    tick(); tick();
    press(4'd8, 6, 6, lat);
    check("keychg_events", strobes - s0, 1);
    check("keychg_lat", lat, 3);
    check_all("digit8", 0, 8, 0, 0, 0, 0);

    // A=81, SUB 2 EQ, then ADD 9 from RESULT
    tap(4'd1); tap(4'd11); tap(4'd2); tap(4'd14);
    check("pre_add.state", state, 2);
    tap(4'd10); tap(4'd9);
    check_all("add9", 8, 1, 0, 9, 0, 1);
    tap(4'd14); tap(4'd6);
    check_all("res_digit6", 0, 6, 0, 0, 0, 0);
    check("rv_count2", rv_cnt, 3);

    // A=12, SUB, B=34, then CLR
    tap(4'd1); tap(4'd2); tap(4'd11); tap(4'd3); tap(4'd4);
    check_all("pre_clr", 1, 2, 3, 4, 1, 1);
    tap(4'd12);
    check_all("clr", 0, 0, 0, 0, 0, 0);

    // reset during a 2-cycle count, key held through reset
    tap(4'd7);
    check("pre_rst.a_one", a_one, 7);
    s0 = strobes;
    key = 4'd5; pressed = 1'b1;
    tick(); tick();
    rst_n = 1'b0;
    #3;
    check("rst_mid.a_one", a_one, 0);
    check("rst_mid.strobe", key_strobe, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (key_strobe && lat < 0) lat = i;
    end
    check("rst_events", strobes - s0, 1);
    check("rst_lat", lat, 3);
    check("rst_digit", a_one, 5);
    pressed = 1'b0;
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
